uart_rx: RTL and testbench

UART receive front end: synchronises the asynchronous `uart_rxd` pin, detects start bits, samples each bit at its midpoint, and presents each received byte as a one-cycle valid pulse. It sits directly downstream of the board RX pin and upstream of the byte-consuming logic in the top-level implementation, which drives the LEDs. It also flags framing errors and line breaks, and optionally checks parity.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 18 +
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and bit-timing derivation.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef UART_RX_PARITY_EN
    , ST_PARITY
`endif
  } rx_state_t;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int unsigned half_bit(input int unsigned cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous pin; both flops reset to 1 (idle line level).
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_ff;

  always_ff @(posedge clk) begin
    if (reset) r_ff <= '1;
    else       r_ff <= {r_ff[0], i_d};
  end

  assign o_q = r_ff[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, mid-bit sampling, framing/break detection.
// Optional even-parity check is compiled in with UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_ferr,
  output logic                    uart_rx_break,
  output logic                    uart_rx_perr
);

  localparam int unsigned CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned HALF  = half_bit(CPB);
  localparam int unsigned CNT_W = $clog2(CPB + 1);
  localparam int unsigned IDX_W = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

  logic                    w_rxd_s;
  logic                    w_par_bad;
  rx_state_t               r_state;
  logic                    r_rxd_prev;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_valid;
  logic                    r_ferr;
  logic                    r_break;
  logic                    r_perr;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (uart_rxd),
    .o_q   (w_rxd_s)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_bad    = r_par_bad;
  assign uart_rx_perr = r_perr;
`else
  assign w_par_bad    = 1'b0;
  assign uart_rx_perr = 1'b0;
`endif

  assign uart_rx_valid = r_valid;
  assign uart_rx_data  = r_data;
  assign uart_rx_ferr  = r_ferr;
  assign uart_rx_break = r_break;

  // r_rxd_prev tracks the previous synchronised level every cycle, so a frame
  // ending with a low stop bit (break/ferr) needs the line to rise before re-arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rxd_prev <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_break    <= 1'b0;
      r_perr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
`endif
    end else begin
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_break    <= 1'b0;
      r_perr     <= 1'b0;
      r_rxd_prev <= w_rxd_s;
      if (!uart_rx_en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            r_idx <= '0;
            if (r_rxd_prev && !w_rxd_s) r_state <= ST_START;
          end
          ST_START: begin
            if (r_cnt == CNT_HALF) begin
              r_cnt   <= '0;
              r_state <= w_rxd_s ? ST_IDLE : ST_DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (r_cnt == CNT_FULL) begin
              r_cnt   <= '0;
              r_shift <= {w_rxd_s, r_shift[PAYLOAD_BITS-1:1]};
              if (r_idx == IDX_LAST) begin
                r_idx <= '0;
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (r_cnt == CNT_FULL) begin
              r_cnt     <= '0;
              r_par_bad <= w_rxd_s ^ (^r_shift);
              r_state   <= ST_STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`endif
          ST_STOP: begin
            if (r_cnt == CNT_FULL) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
              if (w_rxd_s) begin
                if (w_par_bad) begin
                  r_perr <= 1'b1;
                end else begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                end
              end else if (r_shift == '0) begin
                r_break <= 1'b1;
              end else begin
                r_ferr <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table vectors, hand sequences and random frames
// checked against a frame-level outcome model.
module tb_uart_rx;

  localparam int unsigned CLK_HZ   = 1_600_000;
  localparam int unsigned BIT_RATE = 100_000;
  localparam int unsigned P        = 8;
  localparam int unsigned CPB      = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NPAR = 1;
`else
  localparam int unsigned NPAR = 0;
`endif
  localparam int unsigned LAT = 2 + HALF + (P + 1 + NPAR) * CPB;

  typedef enum int {EV_VALID, EV_FERR, EV_BREAK, EV_PERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  data;
    int unsigned at;
  } ev_t;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       pf;
    ev_kind_t   kind;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       en;
  logic       valid;
  logic [7:0] data;
  logic       ferr;
  logic       brk;
  logic       perr;

  int unsigned cyc = 0;
  int unsigned last_start = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  last_good = '0;
  ev_t         obs_q[$];
  ev_t         exp_q[$];
  vec_t        tbl[$];

  uart_rx #(
    .BIT_RATE     (BIT_RATE),
    .CLK_HZ       (CLK_HZ),
    .PAYLOAD_BITS (P)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rxd      (rxd),
    .uart_rx_en    (en),
    .uart_rx_valid (valid),
    .uart_rx_data  (data),
    .uart_rx_ferr  (ferr),
    .uart_rx_break (brk),
    .uart_rx_perr  (perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse monitor: logs each output pulse; at most one may fire per cycle.
  always @(negedge clk) begin
    if (!reset) begin
      int n;
      ev_t e;
      n = int'(valid) + int'(ferr) + int'(brk) + int'(perr);
      if (n != 0) begin
        chk("pulse_exclusive", n, 1);
        e.kind = valid ? EV_VALID : perr ? EV_PERR : brk ? EV_BREAK : EV_FERR;
        e.data = data;
        e.at   = cyc;
        obs_q.push_back(e);
      end
    end
  end

  // Frame-level reference: outcome depends only on stop level, parity and data.
  function automatic ev_kind_t model_kind(input logic [7:0] d, input logic stop, input logic pf);
    if (stop) return (NPAR != 0 && pf) ? EV_PERR : EV_VALID;
    return (d == 8'h00) ? EV_BREAK : EV_FERR;
  endfunction

  task automatic push_exp(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.at   = 0;
    exp_q.push_back(e);
    if (k == EV_VALID) last_good = d;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pf);
    last_start = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pf);
`endif
    send_bit(stop);
    if (!stop) begin
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic compare_events(input string name);
    int n;
    repeat (3 * CPB) @(negedge clk);
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      if (exp_q[i].kind == EV_VALID) chk({name, "_data"}, obs_q[i].data, exp_q[i].data);
    end
    chk({name, "_data_hold"}, data, last_good);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int unsigned lat;
    logic [7:0] d;
    logic st, pf;

    tbl.push_back('{8'h41, 1'b1, 1'b0, EV_VALID});
    tbl.push_back('{8'h00, 1'b1, 1'b0, EV_VALID});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, EV_VALID});
    tbl.push_back('{8'hA5, 1'b1, 1'b0, EV_VALID});
    tbl.push_back('{8'h55, 1'b0, 1'b0, EV_FERR});
    tbl.push_back('{8'h80, 1'b0, 1'b0, EV_FERR});
    tbl.push_back('{8'h00, 1'b0, 1'b0, EV_BREAK});
    tbl.push_back('{8'h3C, 1'b1, 1'b0, EV_VALID});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{8'h03, 1'b1, 1'b0, EV_VALID});
    tbl.push_back('{8'h03, 1'b1, 1'b1, EV_PERR});
`endif

    reset = 1'b1;
    en    = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", valid, 0);
    chk("reset_data", data, 0);
    chk("reset_ferr", ferr, 0);
    chk("reset_break", brk, 0);
    chk("reset_perr", perr, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame with start-edge-to-valid latency.
    send_frame(8'h41, 1'b1, 1'b0);
    push_exp(EV_VALID, 8'h41);
    lat = (obs_q.size() > 0) ? obs_q[0].at - last_start : 0;
    checks++;
    if (lat + 2 < LAT || lat > LAT + 2) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected %0d +/-2", lat, LAT);
    end
    compare_events("first_frame");

    foreach (tbl[i]) begin
      v = tbl[i];
      send_frame(v.d, v.stop, v.pf);
      push_exp(v.kind, v.d);
      compare_events($sformatf("table%0d", i));
    end

    // Back-to-back frames with a single stop bit.
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h32, 1'b1, 1'b0);
    push_exp(EV_VALID, 8'h31);
    push_exp(EV_VALID, 8'h42);
    push_exp(EV_VALID, 8'h32);
    compare_events("back_to_back");

    // Short low glitch is rejected, then a normal frame still decodes.
    rxd = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    compare_events("glitch");
    send_frame(8'h5A, 1'b1, 1'b0);
    push_exp(EV_VALID, 8'h5A);
    compare_events("after_glitch");

    // Line held low for three frame times gives one break.
    rxd = 1'b0;
    repeat (3 * 10 * CPB) @(negedge clk);
    rxd = 1'b1;
    push_exp(EV_BREAK, 8'h00);
    compare_events("held_break");

    // Reset mid-frame aborts it; data register clears.
    d = 8'h61;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rxd   = 1'b1;
    last_good = 8'h00;
    repeat (12 * CPB) @(negedge clk);
    chk("abort_reset_data", data, 0);
    send_frame(8'h62, 1'b1, 1'b0);
    push_exp(EV_VALID, 8'h62);
    compare_events("after_reset");

    // Enable drop mid-frame aborts it; data register holds.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    en = 1'b0;
    @(negedge clk);
    en  = 1'b1;
    rxd = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    compare_events("abort_en");
    send_frame(8'h62, 1'b1, 1'b0);
    push_exp(EV_VALID, 8'h62);
    compare_events("after_en");

    // Random frames checked against the outcome model.
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      pf = (NPAR != 0) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) d = 8'h00;
      send_frame(d, st, pf);
      push_exp(model_kind(d, st, pf), d);
    end
    compare_events("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
